// File: rtl/fas.sv
// 1-bit full adder/subtractor leaf cell.
// Combinational s/cout for chaining plus a registered copy.
module fas (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic a_ns,
  output logic s,
  output logic cout,
  output logic s_q,
  output logic cout_q
);

  logic ax;

  // Sum is the same for add and subtract; inverting a turns carry into borrow.
  always_comb begin
    ax   = a ^ a_ns;
    s    = a ^ b ^ cin;
    cout = (ax & b) | (ax & cin) | (b & cin);
  end

  // Capture the combinational result every edge; reset clears it at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_fas.sv
// Scoreboard bench for fas: single cell, registered path, async reset,
// and a 4-bit ripple chain built from fas cells.
module tb_fas;

  logic clk = 1'b0;
  logic rst;
  logic a, b, cin, a_ns;
  logic s, cout, s_q, cout_q;

  logic [3:0] ca, cb;
  logic       csub;
  logic [4:0] cc;
  logic [3:0] cs;
  logic [3:0] csq, ccq;

  typedef struct {
    string      nm;
    int         sel;
    logic [4:0] exp;
  } item_t;

  item_t sb[$];
  event  chk_ev;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  always #5 clk = ~clk;

  fas dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .a_ns   (a_ns),
    .s      (s),
    .cout   (cout),
    .s_q    (s_q),
    .cout_q (cout_q)
  );

  assign cc[0] = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_chain
    fas u_c (
      .clk    (clk),
      .rst    (rst),
      .a      (ca[g]),
      .b      (cb[g]),
      .cin    (cc[g]),
      .a_ns   (csub),
      .s      (cs[g]),
      .cout   (cc[g+1]),
      .s_q    (csq[g]),
      .cout_q (ccq[g])
    );
  end

  // sel 0: {cout,s}  sel 1: {cout_q,s_q}  sel 2: {borrow/carry, 4-bit result}
  task automatic expect_v(input string nm, input int sel,
                          input logic [4:0] exp);
    item_t it;
    it.nm  = nm;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
    -> chk_ev;
    #1;
  endtask

  // Monitor: pops expectations and compares against what the DUT presents.
  initial begin
    item_t      it;
    logic [4:0] got;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        case (it.sel)
          0:       got = {3'b000, cout, s};
          1:       got = {3'b000, cout_q, s_q};
          default: got = {cc[4], cs};
        endcase
        total_cnt++;
        if (got === it.exp) pass_cnt++;
        else $display("FAIL %s: got %b want %b", it.nm, got, it.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         sum;
    int         diff;
    logic [1:0] e;
    logic [3:0] v;
    rst = 1'b1;
    a = 0; b = 0; cin = 0; a_ns = 0;
    ca = 4'd0; cb = 4'd0; csub = 1'b0;
    #2;
    expect_v("reset_q", 1, 5'b00000);

    @(negedge clk);
    rst = 1'b0;
    expect_v("zero", 0, 5'b00000);
    a = 1; #1;
    expect_v("a1", 0, 5'b00001);
    a = 0; #1;
    expect_v("back0", 0, 5'b00000);

    for (int i = 0; i < 16; i++) begin
      v = i[3:0];
      {a_ns, a, b, cin} = v;
      #1;
      if (v[3] == 1'b0) begin
        sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
        e = sum[1:0];
        expect_v($sformatf("add_%0d%0d%0d", v[2], v[1], v[0]), 0,
                 {3'b000, e});
      end else begin
        diff = int'(v[2]) - int'(v[1]) - int'(v[0]);
        e[0] = diff[0];
        e[1] = (int'(v[2]) < int'(v[1]) + int'(v[0]));
        expect_v($sformatf("sub_%0d%0d%0d", v[2], v[1], v[0]), 0,
                 {3'b000, e});
      end
    end

    a_ns = 0; a = 1; b = 1; cin = 1; #1;
    expect_v("spot_add111", 0, 5'b00011);
    a_ns = 1; a = 0; b = 1; cin = 0; #1;
    expect_v("spot_sub010", 0, 5'b00011);
    a_ns = 1; a = 1; b = 0; cin = 1; #1;
    expect_v("spot_sub101", 0, 5'b00000);

    @(negedge clk);
    a_ns = 0; a = 1; b = 1; cin = 0;
    @(posedge clk); #1;
    expect_v("reg_capture", 1, 5'b00010);
    a = 0; b = 0;
    #1;
    expect_v("reg_hold", 1, 5'b00010);
    expect_v("comb_mid", 0, 5'b00000);
    @(posedge clk); #1;
    expect_v("reg_next", 1, 5'b00000);

    a = 1; b = 0; cin = 0;
    @(posedge clk); #1;
    expect_v("reg_s1", 1, 5'b00001);
    #1;
    rst = 1'b1;
    #1;
    expect_v("async_rst", 1, 5'b00000);
    a = 0; b = 1; cin = 1;
    #1;
    expect_v("comb_in_rst", 0, 5'b00010);
    @(posedge clk); #1;
    expect_v("rst_hold", 1, 5'b00000);
    a = 0; b = 1; cin = 0;
    #1;
    rst = 1'b0;
    #1;
    expect_v("rst_release", 1, 5'b00000);
    @(posedge clk); #1;
    expect_v("first_cap", 1, 5'b00001);

    ca = 4'b0101; cb = 4'b0011; csub = 1'b0; #1;
    expect_v("chain_add", 2, 5'b01000);
    ca = 4'b0011; cb = 4'b0101; csub = 1'b1; #1;
    expect_v("chain_sub", 2, 5'b11110);

    #2;
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
